simon_key_expand: RTL
=====================

// Module: simon_key_expand
// PURPOSE
//  Iterative Simon key-schedule engine, upstream of the Simon round datapath.
//  Accepts one master key, then streams round keys k[0..N_ROUNDS-1], one per handshake.
//  The round datapath consumes one key per round; backpressure stalls expansion.
//  Generic over Simon word size n, key words m (2/3/4) and constant sequence z_j.
// PARAMETERS
//  WORD_W     16  word size n in bits (16,24,32,48,64)
//  KEY_WORDS  4   key words m; legal values 2, 3, 4
//  N_ROUNDS   32  number of round keys emitted per master key (T)
//  CONST_SEQ  0   index j (0..4) of the z_j constant sequence
// PORTS
//  clk        in   1                     rising-edge clock
//  rst_n      in   1                     async active-low reset
//  key_valid  in   1                     master key offered
//  key_ready  out  1                     engine can accept a master key
//  key_in     in   KEY_WORDS*WORD_W      master key; bits [WORD_W-1:0] = k[0], next word = k[1], ...
//  abort      in   1                     sync: drop the current expansion, return to IDLE
//  rk_valid   out  1                     round key available
//  rk_ready   in   1                     consumer accepts round key
//  rk_data    out  WORD_W                round key k[rk_idx]
//  rk_idx     out  $clog2(N_ROUNDS)      round index of rk_data
//  rk_last    out  1                     rk_data is k[N_ROUNDS-1]
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, key regs=0, round cnt=0, z idx=0.
//   Outputs: key_ready=1, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0.
//  FSM states: IDLE, RUN.
//  IDLE: key_ready=1, rk_valid=0.
//   On key_valid&&key_ready: load K[0..m-1] <- key_in words, cnt<=0, zi<=0, go RUN.
//  RUN: key_ready=0 (key_valid ignored), rk_valid=1.
//   rk_data=K[0], rk_idx=cnt, rk_last=(cnt==N_ROUNDS-1).
//  Latency: key accepted at edge t -> rk_valid=1 with k[0] after edge t (1 cycle).
//  On rk_valid&&rk_ready in RUN:
//   - shift: K[i] <= K[i+1] for i<m-1; K[m-1] <= knew; cnt++; zi <= (zi==61)?0:zi+1.
//   - if rk_last: go IDLE, rk_valid=0 next cycle; no extra key emitted.
//  Round-key update, all arithmetic mod 2^WORD_W, ror = rotate right:
//   tmp = ror(K[m-1],3); if m==4: tmp ^= K[1]; tmp ^= ror(tmp,1).
//   knew = ~K[0] ^ tmp ^ z_j[zi] ^ 3. z bit enters LSB only.
//  z_j: 62-bit Simon sequences, index 0 = leftmost bit,
//   e.g. z0 = 11111010001001010110000111001101111101000100101011000011100110.
//   Index wraps 61 -> 0 for N_ROUNDS > 62+m.
//  First m keys are master-key words verbatim, no update applied.
//  Stall: rk_valid=1 && rk_ready=0 -> rk_data/rk_idx/rk_last held stable, no state change.
//   rk_valid never drops until accepted.
//  Back-to-back: after the last accept, key_ready=1 in the next cycle. No overlap with a running expansion.
//  abort=1 in RUN: next cycle state=IDLE, rk_valid=0, key_ready=1.
//   abort has priority over a simultaneous rk handshake. abort in IDLE has no effect.
//  Reset mid-expansion: immediate return to reset values; the partial stream is discarded.
//  Parameter checks (elaboration error): KEY_WORDS not in {2,3,4}; CONST_SEQ>4; N_ROUNDS<KEY_WORDS.
// TESTING
//  1 Simon32/64, key k3..k0 = 1918,1110,0908,0100, rk_ready=1
//    -> rk = 0100,0908,1110,1918,71C3,...; 32 keys total, rk_last on idx 31.
//  2 Same key with rk_ready toggled pseudo-randomly
//    -> identical 32-key stream; rk_data stable during every stall.
//  3 abort asserted after idx 5 accepted, with rk_ready=1 in the same cycle
//    -> no idx 6 emitted, rk_valid=0 next cycle; new key then restarts at idx 0.
//  4 rst_n pulsed low mid-stream at idx 10
//    -> all outputs at reset values immediately; next key restarts cleanly.
//  5 Two keys offered back-to-back
//    -> 2nd key held off (key_ready=0) until 1st key's idx 31 is accepted; streams not interleaved.
//  6 Sweep m=2,3,4 and j=0..4, incl. Simon128/256 (72 rounds, z wrap)
//    -> rk stream matches the simon_pkg key-schedule golden model bit-exactly.

Source files
------------

// File: rtl/simon_key_expand.sv
// Simon key-schedule engine: takes one master key and streams round keys
// k[0..N_ROUNDS-1] over a valid/ready handshake, one new key per accept.
module simon_key_expand #(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4,
  parameter int N_ROUNDS  = 32,
  parameter int CONST_SEQ = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_valid,
  output logic                          key_ready,
  input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
  input  logic                          abort,
  output logic                          rk_valid,
  input  logic                          rk_ready,
  output logic [WORD_W-1:0]             rk_data,
  output logic [$clog2(N_ROUNDS)-1:0]   rk_idx,
  output logic                          rk_last
);

  localparam int IDX_W = $clog2(N_ROUNDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ROUNDS - 1);
  localparam logic [WORD_W-1:0] ROUND_C  = WORD_W'(2'd3);

  // Simon z_j sequences; index 0 of the sequence is the leftmost (MSB) bit.
  function automatic logic [61:0] z_seq(input int j);
    logic [61:0] z_s;
    case (j)
      0: z_s = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1: z_s = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2: z_s = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3: z_s = 62'b11011011101011000110010111100000010010001010011100110100001111;
      4: z_s = 62'b11010001111001101011011000100000010111000011001010010011101111;
      default: z_s = 62'b0;
    endcase
    return z_s;
  endfunction

  function automatic logic [WORD_W-1:0] ror1(input logic [WORD_W-1:0] x);
    return {x[0], x[WORD_W-1:1]};
  endfunction

  function automatic logic [WORD_W-1:0] ror3(input logic [WORD_W-1:0] x);
    return {x[2:0], x[WORD_W-1:3]};
  endfunction

  localparam logic [61:0] Z_BITS = z_seq(CONST_SEQ);

  // Illegal configurations stop elaboration.
  if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_key_words
    $error("simon_key_expand: KEY_WORDS must be 2, 3 or 4");
  end
  if (CONST_SEQ < 0 || CONST_SEQ > 4) begin : g_bad_const_seq
    $error("simon_key_expand: CONST_SEQ must be 0..4");
  end
  if (N_ROUNDS < KEY_WORDS) begin : g_bad_rounds
    $error("simon_key_expand: N_ROUNDS must be >= KEY_WORDS");
  end
  if (WORD_W < 4) begin : g_bad_word_w
    $error("simon_key_expand: WORD_W too small");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [WORD_W-1:0]   key_r [KEY_WORDS];
  logic [WORD_W-1:0]   key_s [KEY_WORDS];
  logic [IDX_W-1:0]    cnt_r, cnt_s;
  logic [5:0]          zi_r, zi_s;
  logic                key_ready_r, rk_valid_r, rk_last_r;
  logic                load_s, shift_s;
  logic [WORD_W-1:0]   tmp_s, knew_s;
  logic                z_bit_s;

  assign key_ready = key_ready_r;
  assign rk_valid  = rk_valid_r;
  assign rk_data   = key_r[0];
  assign rk_idx    = cnt_r;
  assign rk_last   = rk_last_r;

  // Next-state logic: accept a key in IDLE, advance or abort in RUN.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_valid) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (rk_ready) begin
          shift_s = 1'b1;
          if (rk_last_r) begin
            state_s = IDLE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Round-key recurrence computed from the current key window.
  always_comb begin
    z_bit_s = Z_BITS[6'd61 - zi_r];
    tmp_s   = ror3(key_r[KEY_WORDS-1]);
    if (KEY_WORDS == 4) begin
      tmp_s = tmp_s ^ key_r[1];
    end else begin
      tmp_s = tmp_s;
    end
    tmp_s  = tmp_s ^ ror1(tmp_s);
    knew_s = ~key_r[0] ^ tmp_s ^ {{(WORD_W-1){1'b0}}, z_bit_s} ^ ROUND_C;
  end

  // Next values of the key window, round counter and z index.
  always_comb begin
    for (int i = 0; i < KEY_WORDS; i++) begin
      key_s[i] = key_r[i];
    end
    cnt_s = cnt_r;
    zi_s  = zi_r;
    if (load_s) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_s[i] = key_in[i*WORD_W +: WORD_W];
      end
      cnt_s = '0;
      zi_s  = 6'd0;
    end else if (shift_s) begin
      for (int i = 0; i < KEY_WORDS - 1; i++) begin
        key_s[i] = key_r[i+1];
      end
      key_s[KEY_WORDS-1] = knew_s;
      cnt_s = cnt_r + IDX_W'(1);
      zi_s  = (zi_r == 6'd61) ? 6'd0 : zi_r + 6'd1;
    end else begin
      cnt_s = cnt_r;
      zi_s  = zi_r;
    end
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_r[i] <= '0;
      end
      cnt_r       <= '0;
      zi_r        <= 6'd0;
      key_ready_r <= 1'b1;
      rk_valid_r  <= 1'b0;
      rk_last_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_r[i] <= key_s[i];
      end
      cnt_r       <= cnt_s;
      zi_r        <= zi_s;
      key_ready_r <= (state_s == IDLE);
      rk_valid_r  <= (state_s == RUN);
      rk_last_r   <= (state_s == RUN) && (cnt_s == LAST_IDX);
    end
  end

endmodule
